branch_resolve: RTL and testbench

Resolves conditional branches flagged by the ID-stage predictor: carries each branch's prediction through EX and MEM, evaluates the real condition in EX on forwarded operands, and registers the outcome into MEM. At MEM it detects mispredictions, supplies the redirect PC and the flush request, and drives the one-shot training port (`branchM`, `actual_takeM`, `pcM`) back to the predictor. It also keeps saturating branch and misprediction counters for performance analysis.

---
 rtl/branch_resolve_pkg.sv | 33 +++
 rtl/branch_cmp.sv | 37 +++
 rtl/branch_resolve.sv | 127 ++++++++++++
 tb/tb_branch_resolve.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_pkg.sv
// Shared definitions for branch resolution: branch opcodes, the EX/MEM
// payload records and the target-address helper.
package branch_resolve_pkg;

  localparam logic [5:0] EXE_REGIMM = 6'b000001;
  localparam logic [5:0] EXE_BEQ    = 6'b000100;
  localparam logic [5:0] EXE_BNE    = 6'b000101;
  localparam logic [5:0] EXE_BLEZ   = 6'b000110;
  localparam logic [5:0] EXE_BGTZ   = 6'b000111;

  typedef struct packed {
    logic        likely;
    logic        pred;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
  } ex_data_t;

  typedef struct packed {
    logic        likely;
    logic        pred;
    logic        take;
    logic [31:0] pc;
    logic [31:0] target;
  } mem_data_t;

  // Wraps modulo 2^32 by construction.
  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic [31:0] imm);
    return pc + 32'd4 + (imm << 2);
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch-condition evaluator for conditional branches; any
// encoding that is not a recognised conditional branch resolves not-taken.
module branch_cmp
  import branch_resolve_pkg::*;
(
  input  logic        [31:0] i_instr,
  input  logic signed [31:0] i_rs,
  input  logic signed [31:0] i_rt,
  output logic               o_take
);

  logic [5:0] w_op;
  logic       w_regimm_br;
  logic       w_unused_fields;

  assign w_op        = i_instr[31:26];
  // REGIMM rt codes 000x0/000x1 and 100x0/100x1: bltz/bgez, their L and AL forms.
  assign w_regimm_br = (i_instr[19:17] == 3'b000) || (i_instr[19:17] == 3'b001);
  assign w_unused_fields = &{i_instr[25:20], i_instr[15:0]};

  always_comb begin
    o_take = 1'b0;
    case (w_op)
      EXE_BEQ:    o_take = (i_rs == i_rt);
      EXE_BNE:    o_take = (i_rs != i_rt);
      EXE_BLEZ:   o_take = (i_rs <= 32'sd0);
      EXE_BGTZ:   o_take = (i_rs >  32'sd0);
      EXE_REGIMM: begin
        if (w_regimm_br) begin
          o_take = i_instr[16] ? (i_rs >= 32'sd0) : (i_rs < 32'sd0);
        end
      end
      default:    o_take = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Carries predicted branches from ID through EX and MEM, resolves them in EX,
// and at MEM drives redirect, likely-nullify, predictor training and counters.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallE,
  input  logic             stallM,
  input  logic             flushE,
  input  logic             flushM,
  input  logic             branchD,
  input  logic             branchL_D,
  input  logic             pred_takeD,
  input  logic [31:0]      pcD,
  input  logic [31:0]      instrD,
  input  logic [31:0]      immD,
  input  logic [31:0]      rs_valueE,
  input  logic [31:0]      rt_valueE,
  output logic             branchM,
  output logic             actual_takeM,
  output logic [31:0]      pcM,
  output logic             mispredictM,
  output logic [31:0]      pc_correctM,
  output logic             likely_nullifyM,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic             r_vld_p1;
  ex_data_t         r_ex_p1;
  logic             r_vld_p2;
  mem_data_t        r_mem_p2;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  logic             w_take_p1;
  logic [31:0]      w_target_p1;
  logic             w_fire_p2;
  logic             w_mispred_p2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // EX stage: capture the ID-stage branch and its prediction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
    end else if (flushE) begin
      r_vld_p1 <= 1'b0;
    end else if (!stallE) begin
      r_vld_p1 <= branchD;
    end
  end

  always_ff @(posedge clk) begin
    if (!stallE) begin
      r_ex_p1.likely <= branchL_D;
      r_ex_p1.pred   <= pred_takeD;
      r_ex_p1.pc     <= pcD;
      r_ex_p1.instr  <= instrD;
      r_ex_p1.imm    <= immD;
    end
  end

  branch_cmp u_cmp (
    .i_instr (r_ex_p1.instr),
    .i_rs    (rs_valueE),
    .i_rt    (rt_valueE),
    .o_take  (w_take_p1)
  );

  assign w_target_p1 = branch_target(r_ex_p1.pc, r_ex_p1.imm);

  // MEM stage: register the resolved outcome; a stalled EX feeds a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2 <= 1'b0;
    end else if (flushM) begin
      r_vld_p2 <= 1'b0;
    end else if (!stallM) begin
      r_vld_p2 <= stallE ? 1'b0 : r_vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (!stallM) begin
      r_mem_p2.likely <= r_ex_p1.likely;
      r_mem_p2.pred   <= r_ex_p1.pred;
      r_mem_p2.take   <= w_take_p1;
      r_mem_p2.pc     <= r_ex_p1.pc;
      r_mem_p2.target <= w_target_p1;
    end
  end

  // Gating on ~stallM gives one training pulse per branch however long MEM holds.
  assign w_fire_p2    = r_vld_p2 & ~stallM;
  assign w_mispred_p2 = w_fire_p2 & (r_mem_p2.take != r_mem_p2.pred);

  assign branchM         = w_fire_p2;
  assign actual_takeM    = w_fire_p2 & r_mem_p2.take;
  assign pcM             = w_fire_p2 ? r_mem_p2.pc : 32'd0;
  assign mispredictM     = w_mispred_p2;
  assign pc_correctM     = !w_fire_p2     ? 32'd0 :
                           r_mem_p2.take  ? r_mem_p2.target :
                                            r_mem_p2.pc + 32'd8;
  assign likely_nullifyM = w_fire_p2 & r_mem_p2.likely & ~r_mem_p2.take;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (w_fire_p2) begin
      r_branch_cnt <= sat_inc(r_branch_cnt);
      if (w_mispred_p2) begin
        r_mispred_cnt <= sat_inc(r_mispred_cnt);
      end
    end
  end

  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed vector table, hand-built pipeline corner
// sequences and randomized traffic against a stage-level reference model.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst, stallE, stallM, flushE, flushM;
  logic        branchD, branchL_D, pred_takeD;
  logic [31:0] pcD, instrD, immD, rs_valueE, rt_valueE;

  logic        branchM, actual_takeM, mispredictM, likely_nullifyM;
  logic [31:0] pcM, pc_correctM, branch_cnt, mispred_cnt;
  logic        s_branchM, s_actual_takeM, s_mispredictM, s_likely_nullifyM;
  logic [31:0] s_pcM, s_pc_correctM;
  logic [3:0]  s_branch_cnt, s_mispred_cnt;

  always #5 clk = ~clk;

  branch_resolve #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stallE(stallE), .stallM(stallM),
    .flushE(flushE), .flushM(flushM), .branchD(branchD),
    .branchL_D(branchL_D), .pred_takeD(pred_takeD), .pcD(pcD),
    .instrD(instrD), .immD(immD), .rs_valueE(rs_valueE),
    .rt_valueE(rt_valueE), .branchM(branchM), .actual_takeM(actual_takeM),
    .pcM(pcM), .mispredictM(mispredictM), .pc_correctM(pc_correctM),
    .likely_nullifyM(likely_nullifyM), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  // Narrow-counter copy on the same inputs, to reach saturation quickly.
  branch_resolve #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .stallE(stallE), .stallM(stallM),
    .flushE(flushE), .flushM(flushM), .branchD(branchD),
    .branchL_D(branchL_D), .pred_takeD(pred_takeD), .pcD(pcD),
    .instrD(instrD), .immD(immD), .rs_valueE(rs_valueE),
    .rt_valueE(rt_valueE), .branchM(s_branchM), .actual_takeM(s_actual_takeM),
    .pcM(s_pcM), .mispredictM(s_mispredictM), .pc_correctM(s_pc_correctM),
    .likely_nullifyM(s_likely_nullifyM), .branch_cnt(s_branch_cnt),
    .mispred_cnt(s_mispred_cnt)
  );

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    bit v, l, p;
    logic [31:0] pc, instr, imm;
  } ex_m_t;
  typedef struct {
    bit v, l, p, t;
    logic [31:0] pc, tgt;
  } mem_m_t;

  ex_m_t   mex;
  mem_m_t  mmem;
  longint  m_bc, m_mc;

  typedef struct {
    logic [31:0] instr, imm, pc, rs, rt;
    bit          pred, likely;
    bit          e_take, e_mis, e_null;
    logic [31:0] e_pcc;
  } vec_t;
  vec_t tbl[10];

  function automatic bit ref_take(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt);
    bit neg  = rs[31];
    bit zero = (rs == 32'd0);
    case (ins[31:26])
      6'd4:    return rs == rt;
      6'd5:    return rs != rt;
      6'd6:    return neg || zero;
      6'd7:    return !neg && !zero;
      6'd1:    return (ins[19:18] == 2'b00) ? (ins[16] ? !neg : neg) : 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] sat_cnt(longint c, int w);
    longint mx = (longint'(1) << w) - 1;
    return (c > mx) ? 32'(mx) : 32'(c);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic settle_and_check();
    bit fire;
    #1;
    fire = mmem.v && !stallM;
    chk("branchM", branchM, fire);
    chk("actual_takeM", actual_takeM, fire && mmem.t);
    chk("pcM", pcM, fire ? mmem.pc : 32'd0);
    chk("mispredictM", mispredictM, fire && (mmem.t != mmem.p));
    chk("pc_correctM", pc_correctM, fire ? (mmem.t ? mmem.tgt : mmem.pc + 32'd8) : 32'd0);
    chk("likely_nullifyM", likely_nullifyM, fire && mmem.l && !mmem.t);
    chk("branch_cnt", branch_cnt, sat_cnt(m_bc, 32));
    chk("mispred_cnt", mispred_cnt, sat_cnt(m_mc, 32));
    chk("sat_branch_cnt", 32'(s_branch_cnt), sat_cnt(m_bc, 4));
    chk("sat_mispred_cnt", 32'(s_mispred_cnt), sat_cnt(m_mc, 4));
  endtask

  task automatic clock_edge();
    if (rst) begin
      mex.v = 0; mmem.v = 0; m_bc = 0; m_mc = 0;
    end else begin
      if (mmem.v && !stallM) begin
        m_bc++;
        if (mmem.t != mmem.p) m_mc++;
      end
      if (flushM) mmem.v = 0;
      else if (!stallM) begin
        if (stallE) mmem.v = 0;
        else begin
          mmem.v   = mex.v;
          mmem.l   = mex.l;
          mmem.p   = mex.p;
          mmem.pc  = mex.pc;
          mmem.t   = ref_take(mex.instr, rs_valueE, rt_valueE);
          mmem.tgt = mex.pc + 32'd4 + mex.imm * 32'd4;
        end
      end
      if (flushE) mex.v = 0;
      else if (!stallE) begin
        mex.v = branchD; mex.l = branchL_D; mex.p = pred_takeD;
        mex.pc = pcD; mex.instr = instrD; mex.imm = immD;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; stallE = 0; stallM = 0; flushE = 0; flushM = 0;
    branchD = 0; branchL_D = 0; pred_takeD = 0; instrD = 32'd0;
  endtask

  task automatic drive_br(logic [31:0] ins, logic [31:0] imm, logic [31:0] pc,
                          bit pred, bit likely);
    branchD = 1; instrD = ins; immD = imm; pcD = pc;
    pred_takeD = pred; branchL_D = likely;
  endtask

  localparam logic [31:0] BEQ = 32'h10220008;

  initial begin
    int exp_mis_total;
    longint bc0;
    idle();
    pcD = 0; immD = 0; rs_valueE = 0; rt_valueE = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    mex.v = 0; mmem.v = 0; m_bc = 0; m_mc = 0;
    rst = 0;
    settle_and_check();
    chk("rst_branchM", branchM, 0);
    chk("rst_pc_correctM", pc_correctM, 0);
    chk("rst_pcM", pcM, 0);
    chk("rst_branch_cnt", branch_cnt, 0);
    clock_edge();

    tbl[0] = '{32'h10220004, 32'h00000004, 32'h00400010, 32'd5, 32'd5, 0, 0, 1, 1, 0, 32'h00400024};
    tbl[1] = '{32'h1C400010, 32'h00000010, 32'h00400100, 32'hFFFFFFFF, 32'd0, 1, 0, 0, 1, 0, 32'h00400108};
    tbl[2] = '{32'h0462FFFC, 32'hFFFFFFFC, 32'h00400200, 32'd1, 32'd0, 0, 1, 0, 0, 1, 32'h00400208};
    tbl[3] = '{32'h1422FFFE, 32'hFFFFFFFE, 32'h00400300, 32'd1, 32'd2, 1, 0, 1, 0, 0, 32'h004002FC};
    tbl[4] = '{32'h18800001, 32'h00000001, 32'h00000010, 32'd0, 32'd9, 1, 0, 1, 0, 0, 32'h00000018};
    tbl[5] = '{32'h04B10000, 32'h00000000, 32'h00000020, 32'd0, 32'd0, 0, 0, 1, 1, 0, 32'h00000024};
    tbl[6] = '{32'h10220010, 32'h00000010, 32'hFFFFFFF0, 32'hDEADBEEF, 32'hDEADBEEF, 1, 0, 1, 0, 0, 32'h00000034};
    tbl[7] = '{32'h20220004, 32'h00000004, 32'h00000040, 32'd3, 32'd3, 1, 0, 0, 1, 0, 32'h00000048};
    tbl[8] = '{32'h04240003, 32'h00000003, 32'h00000050, 32'h80000000, 32'd0, 0, 1, 0, 0, 1, 32'h00000058};
    tbl[9] = '{32'h0462FFFC, 32'hFFFFFFFC, 32'h00000100, 32'h80000000, 32'd0, 1, 1, 1, 0, 0, 32'h000000F4};

    exp_mis_total = 0;
    for (int i = 0; i < 10; i++) begin
      idle(); drive_br(tbl[i].instr, tbl[i].imm, tbl[i].pc, tbl[i].pred, tbl[i].likely);
      settle_and_check(); clock_edge();
      idle(); rs_valueE = tbl[i].rs; rt_valueE = tbl[i].rt;
      settle_and_check(); clock_edge();
      idle(); rs_valueE = $urandom; rt_valueE = $urandom;
      settle_and_check();
      chk($sformatf("tbl%0d_branchM", i), branchM, 1);
      chk($sformatf("tbl%0d_take", i), actual_takeM, tbl[i].e_take);
      chk($sformatf("tbl%0d_mispred", i), mispredictM, tbl[i].e_mis);
      chk($sformatf("tbl%0d_nullify", i), likely_nullifyM, tbl[i].e_null);
      chk($sformatf("tbl%0d_pc_correct", i), pc_correctM, tbl[i].e_pcc);
      chk($sformatf("tbl%0d_pcM", i), pcM, tbl[i].pc);
      exp_mis_total += int'(tbl[i].e_mis);
      clock_edge();
      settle_and_check();
      chk($sformatf("tbl%0d_mis_cnt", i), mispred_cnt, exp_mis_total);
      chk($sformatf("tbl%0d_br_cnt", i), branch_cnt, i + 1);
      clock_edge();
    end

    // MEM held three cycles: exactly one training pulse
    bc0 = m_bc;
    idle(); drive_br(BEQ, 32'd8, 32'h1000, 1, 0); settle_and_check(); clock_edge();
    idle(); rs_valueE = 7; rt_valueE = 7; settle_and_check(); clock_edge();
    for (int k = 0; k < 3; k++) begin
      idle(); stallM = 1; settle_and_check();
      chk("stallM_hold_branchM", branchM, 0); clock_edge();
    end
    idle(); settle_and_check(); chk("stallM_release_branchM", branchM, 1); clock_edge();
    idle(); settle_and_check(); chk("stallM_after_branchM", branchM, 0);
    chk("stallM_branch_cnt", branch_cnt, 32'(bc0 + 1)); clock_edge();

    // flushE coincident with branchD
    idle(); drive_br(BEQ, 32'd8, 32'h2000, 0, 0); flushE = 1; settle_and_check(); clock_edge();
    idle(); rs_valueE = 1; rt_valueE = 1; settle_and_check(); clock_edge();
    idle(); settle_and_check(); chk("flushE_no_pulse", branchM, 0); clock_edge();

    // stallE for one cycle: bubble then resolution one cycle late
    idle(); drive_br(BEQ, 32'd8, 32'h3000, 0, 0); settle_and_check(); clock_edge();
    idle(); stallE = 1; rs_valueE = 4; rt_valueE = 4; settle_and_check(); clock_edge();
    idle(); settle_and_check(); chk("stallE_bubble", branchM, 0); clock_edge();
    idle(); settle_and_check(); chk("stallE_late_branchM", branchM, 1);
    chk("stallE_late_take", actual_takeM, 1); chk("stallE_late_pcM", pcM, 32'h3000); clock_edge();

    // back-to-back branches
    idle(); drive_br(BEQ, 32'd8, 32'h4000, 1, 0); settle_and_check(); clock_edge();
    idle(); drive_br(BEQ, 32'd8, 32'h4008, 1, 0); rs_valueE = 2; rt_valueE = 2;
    settle_and_check(); clock_edge();
    idle(); rs_valueE = 2; rt_valueE = 3; settle_and_check();
    chk("b2b_first_branchM", branchM, 1); chk("b2b_first_pcM", pcM, 32'h4000);
    chk("b2b_first_take", actual_takeM, 1); clock_edge();
    idle(); settle_and_check();
    chk("b2b_second_branchM", branchM, 1); chk("b2b_second_pcM", pcM, 32'h4008);
    chk("b2b_second_take", actual_takeM, 0); clock_edge();

    // flushM raised by our own mispredict: outputs valid this cycle, bubble next
    idle(); drive_br(BEQ, 32'd8, 32'h5000, 0, 0); settle_and_check(); clock_edge();
    idle(); rs_valueE = 9; rt_valueE = 9; settle_and_check(); clock_edge();
    idle(); flushM = 1; flushE = 1; settle_and_check();
    chk("own_flush_branchM", branchM, 1); chk("own_flush_mispred", mispredictM, 1);
    chk("own_flush_pc_correct", pc_correctM, 32'h5024); clock_edge();
    idle(); settle_and_check(); chk("own_flush_bubble", branchM, 0); clock_edge();

    // reset mid-stream drops in-flight branches
    idle(); drive_br(BEQ, 32'd8, 32'h6000, 0, 0); settle_and_check(); clock_edge();
    idle(); drive_br(BEQ, 32'd8, 32'h6008, 0, 0); rst = 1; rs_valueE = 1; rt_valueE = 1;
    settle_and_check(); clock_edge();
    idle(); settle_and_check();
    chk("rst_mid_branchM", branchM, 0); chk("rst_mid_pc_correct", pc_correctM, 0);
    chk("rst_mid_branch_cnt", branch_cnt, 0); chk("rst_mid_mispred_cnt", mispred_cnt, 0);
    clock_edge();
    idle(); settle_and_check(); chk("rst_mid_dropped", branchM, 0); clock_edge();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] ins, rsv;
      int sel;
      idle();
      rst    = ($urandom_range(0, 199) == 0);
      stallE = ($urandom_range(0, 6) == 0);
      stallM = ($urandom_range(0, 6) == 0);
      flushE = ($urandom_range(0, 9) == 0);
      flushM = ($urandom_range(0, 9) == 0);
      branchD    = $urandom_range(0, 1);
      branchL_D  = $urandom_range(0, 1);
      pred_takeD = $urandom_range(0, 1);
      ins = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0: ins[31:26] = 6'd1;
        1: ins[31:26] = 6'd4;
        2: ins[31:26] = 6'd5;
        3: ins[31:26] = 6'd6;
        4: ins[31:26] = 6'd7;
        default: ;
      endcase
      instrD = ins;
      immD   = {{16{ins[15]}}, ins[15:0]};
      pcD    = {$urandom, 2'b00};
      case ($urandom_range(0, 4))
        0: rsv = 32'd0;
        1: rsv = 32'hFFFFFFFF;
        2: rsv = 32'h80000000;
        3: rsv = 32'd1;
        default: rsv = $urandom;
      endcase
      rs_valueE = rsv;
      rt_valueE = $urandom_range(0, 1) ? rsv : $urandom;
      settle_and_check();
      clock_edge();
    end

    // saturation of the narrow counters
    idle(); rst = 1; settle_and_check(); clock_edge();
    for (int k = 0; k < 20; k++) begin
      idle(); drive_br(32'h18800001, 32'd1, 32'h7000 + 32'(k * 8), 0, 0);
      rs_valueE = 0; rt_valueE = 0;
      settle_and_check(); clock_edge();
    end
    for (int k = 0; k < 3; k++) begin
      idle(); rs_valueE = 0; settle_and_check(); clock_edge();
    end
    idle(); settle_and_check();
    chk("sat_branch_cnt_allones", 32'(s_branch_cnt), 32'hF);
    chk("sat_mispred_cnt_allones", 32'(s_mispred_cnt), 32'hF);
    chk("wide_branch_cnt_20", branch_cnt, 32'd20);
    chk("wide_mispred_cnt_20", mispred_cnt, 32'd20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
